// File: rtl/mem_access.sv
// MEM stage of the five-stage pipeline: loads/stores over a single-outstanding req/ack bus, results to MEM/WB.
// Optional build macro MEM_ALIGN_CHECK_EN enables misaligned-access detection (o_misalign); otherwise o_misalign is tied 0.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic        i_wreg,
    input  logic        i_whilo,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [3:0]  i_memop,
    input  logic [31:0] i_maddr,
    input  logic [31:0] i_sdata,
    input  logic [5:0]  stall_i,
    output logic        stallreq_o,
    output logic [4:0]  o_waddr,
    output logic        o_wreg,
    output logic [31:0] o_wdata,
    output logic        o_whilo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        o_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t      state;
    logic [31:0] rdata_q;
    logic        is_load;
    logic        is_store;
    logic        misalign;
    logic        start;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] load_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    logic unused_stall;
    assign unused_stall = ^{stall_i[5], stall_i[3:0]};

    always_comb begin
        is_load  = (i_memop >= OP_LB) && (i_memop <= OP_LW);
        is_store = (i_memop >= OP_SB) && (i_memop <= OP_SW);
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (i_memop)
            OP_LH, OP_LHU, OP_SH: misalign = i_maddr[0];
            OP_LW, OP_SW:         misalign = |i_maddr[1:0];
            default:              misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // A misaligned access is squashed in IDLE: no bus cycle, no stall, no write-back.
    assign start      = (state == IDLE) && (is_load || is_store) && !misalign;
    assign stallreq_o = start || (state == REQ);
    assign o_misalign = (state == IDLE) && misalign;

    // Big-endian lanes: byte offset 0 is bits [31:24] and be[3].
    always_comb begin
        be_nxt    = 4'b0000;
        wdata_nxt = i_sdata;
        case (i_memop)
            OP_SB: begin
                be_nxt    = 4'b1000 >> i_maddr[1:0];
                wdata_nxt = {4{i_sdata[7:0]}};
            end
            OP_SH: begin
                be_nxt    = i_maddr[1] ? 4'b0011 : 4'b1100;
                wdata_nxt = {2{i_sdata[15:0]}};
            end
            OP_SW:  be_nxt = 4'b1111;
            OP_LB, OP_LBU: be_nxt = 4'b1000 >> i_maddr[1:0];
            OP_LH, OP_LHU: be_nxt = i_maddr[1] ? 4'b0011 : 4'b1100;
            OP_LW:  be_nxt = 4'b1111;
            default: be_nxt = 4'b0000;
        endcase
    end

    always_comb begin
        case (i_maddr[1:0])
            2'd0:    lane_b = rdata_q[31:24];
            2'd1:    lane_b = rdata_q[23:16];
            2'd2:    lane_b = rdata_q[15:8];
            default: lane_b = rdata_q[7:0];
        endcase
        lane_h = i_maddr[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (i_memop)
            OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_data = {24'd0, lane_b};
            OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_data = {16'd0, lane_h};
            default: load_data = rdata_q;
        endcase
    end

    assign o_waddr = i_waddr;
    assign o_wreg  = i_wreg && !o_misalign;
    assign o_wdata = is_load ? load_data : i_wdata;
    assign o_whilo = i_whilo;
    assign o_hi    = i_hi;
    assign o_lo    = i_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_addr  <= {i_maddr[31:2], 2'b00};
                        bus_be    <= be_nxt;
                        bus_wdata <= wdata_nxt;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        rdata_q <= bus_rdata;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // Held here while MEM is stalled so the same op is not reissued.
                    if (!stall_i[4])
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: hand-computed vectors, immediate assertions, one summary line.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  i_waddr = 5'd17;
    logic [31:0] i_wdata = 32'hDEADBEEF;
    logic        i_wreg = 1'b1;
    logic        i_whilo = 1'b1;
    logic [31:0] i_hi = 32'h0000_1111;
    logic [31:0] i_lo = 32'h0000_2222;
    logic [3:0]  i_memop = 4'd0;
    logic [31:0] i_maddr = 32'd0;
    logic [31:0] i_sdata = 32'd0;
    logic [5:0]  stall_i = 6'd0;
    logic        stallreq_o;
    logic [4:0]  o_waddr;
    logic        o_wreg;
    logic [31:0] o_wdata;
    logic        o_whilo;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ack = 1'b0;
    logic        o_misalign;

    int vectors = 0;
    int errors  = 0;

    mem_access dut (
        .clk(clk), .rst(rst),
        .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wreg(i_wreg),
        .i_whilo(i_whilo), .i_hi(i_hi), .i_lo(i_lo),
        .i_memop(i_memop), .i_maddr(i_maddr), .i_sdata(i_sdata),
        .stall_i(stall_i), .stallreq_o(stallreq_o),
        .o_waddr(o_waddr), .o_wreg(o_wreg), .o_wdata(o_wdata),
        .o_whilo(o_whilo), .o_hi(o_hi), .o_lo(o_lo),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .o_misalign(o_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: IDLE -> REQ (waits+1 cycles) -> DONE -> IDLE.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int waits,
                          input logic we, input logic [3:0] be, input logic [31:0] bwd,
                          input logic [31:0] exp_wd);
        int stalls = 0;
        i_memop = op; i_maddr = addr; i_sdata = sdata;
        #1;
        if (stallreq_o) stalls++;
        chk({tag, " idle bus_req"}, {31'd0, bus_req}, 32'd0);
        tick();
        for (int w = 0; w <= waits; w++) begin
            if (stallreq_o) stalls++;
            chk({tag, " req bus_req"}, {31'd0, bus_req}, 32'd1);
            chk({tag, " bus_we"}, {31'd0, bus_we}, {31'd0, we});
            chk({tag, " bus_be"}, {28'd0, bus_be}, {28'd0, be});
            chk({tag, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
            chk({tag, " bus_wdata"}, bus_wdata, bwd);
            if (w == waits) begin
                bus_ack = 1'b1; bus_rdata = rdata;
            end
            tick();
            bus_ack = 1'b0; bus_rdata = 32'h5555_AAAA;
        end
        #1;
        if (stallreq_o) stalls++;
        chk({tag, " stall cycles"}, stalls, waits + 2);
        chk({tag, " done bus_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, " o_wdata"}, o_wdata, exp_wd);
        i_memop = 4'd0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'd0);
        chk("rst stall", {31'd0, stallreq_o}, 32'd0);
        chk("rst misalign", {31'd0, o_misalign}, 32'd0);
        chk("pass waddr", {27'd0, o_waddr}, 32'd17);
        chk("pass wreg", {31'd0, o_wreg}, 32'd1);
        chk("pass whilo", {31'd0, o_whilo}, 32'd1);
        chk("pass hi", o_hi, 32'h0000_1111);
        chk("pass lo", o_lo, 32'h0000_2222);
        chk("none wdata", o_wdata, 32'hDEADBEEF);

        // Reserved opcode and stray ack: no stall, no bus activity.
        i_memop = 4'd12; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        #1;
        chk("op12 stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        bus_ack = 1'b0;
        chk("op12 bus_req", {31'd0, bus_req}, 32'd0);
        chk("op12 wdata", o_wdata, 32'hDEADBEEF);
        i_memop = 4'd0;

        run_op("lw",  4'd5, 32'h0000_0100, 32'd0, 32'h1122_3344, 0, 1'b0, 4'b1111, 32'd0, 32'h1122_3344);
        run_op("lb",  4'd1, 32'h0000_0103, 32'd0, 32'h0000_00F0, 0, 1'b0, 4'b0001, 32'd0, 32'hFFFF_FFF0);
        run_op("lbu", 4'd2, 32'h0000_0103, 32'd0, 32'h0000_00F0, 0, 1'b0, 4'b0001, 32'd0, 32'h0000_00F0);
        run_op("sh",  4'd7, 32'h0000_0202, 32'hABCD_1234, 32'd0, 3, 1'b1, 4'b0011, 32'h1234_1234, 32'hDEADBEEF);
        run_op("sb",  4'd6, 32'h0000_0101, 32'h1234_565A, 32'd0, 1, 1'b1, 4'b0100, 32'h5A5A_5A5A, 32'hDEADBEEF);
        run_op("lh",  4'd3, 32'h0000_0102, 32'd0, 32'h1234_8765, 0, 1'b0, 4'b0011, 32'd0, 32'hFFFF_8765);
        run_op("lhu", 4'd4, 32'h0000_0102, 32'd0, 32'h1234_8765, 2, 1'b0, 4'b0011, 32'd0, 32'h0000_8765);
        run_op("lb0", 4'd1, 32'h0000_0400, 32'd0, 32'h7F80_0000, 0, 1'b0, 4'b1000, 32'd0, 32'h0000_007F);
        run_op("sw",  4'd8, 32'h0000_0300, 32'hA5A5_F00F, 32'd0, 1, 1'b1, 4'b1111, 32'hA5A5_F00F, 32'hDEADBEEF);

        // DONE held by stall_i[4]: no stall, no reissue, stable result.
        i_memop = 4'd5; i_maddr = 32'h0000_0500;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h0BAD_CAFE;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'd0; stall_i = 6'b010000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold stall", {31'd0, stallreq_o}, 32'd0);
            chk("hold bus_req", {31'd0, bus_req}, 32'd0);
            chk("hold wdata", o_wdata, 32'h0BAD_CAFE);
            tick();
        end
        stall_i = 6'd0;
        i_memop = 4'd0;
        tick();

        // Reset in REQ with a coincident ack: the ack is discarded.
        i_memop = 4'd5; i_maddr = 32'h0000_0100;
        tick();
        chk("rstreq bus_req before", {31'd0, bus_req}, 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D; rst = 1'b1;
        tick();
        rst = 1'b0; bus_ack = 1'b0;
        #1;
        chk("rstreq bus_req", {31'd0, bus_req}, 32'd0);
        chk("rstreq bus_addr", bus_addr, 32'd0);
        chk("rstreq rdata_q", o_wdata, 32'd0);
        i_memop = 4'd0;
        #1;
        chk("rstreq idle", {31'd0, stallreq_o}, 32'd0);
        tick();

        // Misaligned word load.
        i_memop = 4'd5; i_maddr = 32'h0000_0101;
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis flag", {31'd0, o_misalign}, 32'd1);
        chk("mis wreg", {31'd0, o_wreg}, 32'd0);
        chk("mis stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        chk("mis bus_req", {31'd0, bus_req}, 32'd0);
        chk("mis still idle", {31'd0, o_misalign}, 32'd1);
`else
        chk("mis flag off", {31'd0, o_misalign}, 32'd0);
        chk("mis wreg off", {31'd0, o_wreg}, 32'd1);
        chk("mis stall off", {31'd0, stallreq_o}, 32'd1);
`endif
        i_memop = 4'd0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
